// File: rtl/bitbanger_pkg.sv
// bitbanger_pkg: shared FSM encoding and frame constants for the bit-banger receiver
package bitbanger_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;
  localparam int MIN_DIV   = 4;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/bitbanger_fifo.sv
// bitbanger_fifo: synchronous first-word-fall-through FIFO
//   clk, reset (async, active-low) | wr_en, wr_data: push | rd_en: pop when non-empty
//   rd_data: head entry (0 when empty) | full, empty: occupancy flags
module bitbanger_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic pop, push;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop = rd_en && !empty;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  assign push = wr_en && (!full || pop);
  assign rd_data = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= wr_data;
endmodule

// File: rtl/bitbanger_rx.sv
// bitbanger_rx: 8N1 receiver for the CoCo bit-banger output with a FWFT byte FIFO
//   clk: system clock | reset: async active-low | rx_line: serial input (rsout1)
//   baud_div: clocks per bit, clamped to >= 4, latched at start detection
//   rx_data, rx_valid, rx_ready: byte stream out | frame_err: bad stop bit pulse
//   overrun, overrun_clr: sticky drop flag and its clear | rx_busy: frame in progress
module bitbanger_rx
  import bitbanger_pkg::*;
#(
  parameter int DIV_W      = 17,
  parameter int FIFO_DEPTH = 8,
  parameter bit INVERT     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_line,
  input  logic [DIV_W-1:0] baud_div,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             rx_busy
);
  localparam int IW = $clog2(DATA_BITS);
  rx_state_t state;
  logic s1, s2, s, s_prev, fall, tick, drop;
  logic [2:0] warm;
  logic [DIV_W-1:0] cnt, p, pn;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] sh, push_d;
  logic push_v, fifo_full, fifo_empty;
  assign s = s2 ^ INVERT;
  // warm marks when s carries real line samples rather than the reset preload,
  // so a line that is already low at reset release never looks like a falling edge
  assign fall = warm[2] && s_prev && !s;
  assign tick = cnt == '0;
  assign pn = baud_div < DIV_W'(MIN_DIV) ? DIV_W'(MIN_DIV) : baud_div;
  assign rx_busy = state != IDLE;
  assign rx_valid = !fifo_empty;
  assign drop = push_v && fifo_full && !(rx_valid && rx_ready);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s_prev <= 1'b1;
      warm <= '0;
    end else begin
      s1 <= rx_line;
      s2 <= s1;
      s_prev <= s;
      warm <= {warm[1:0], 1'b1};
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      p <= '0;
      idx <= '0;
      sh <= '0;
      push_v <= 1'b0;
      push_d <= '0;
      frame_err <= 1'b0;
    end else begin
      push_v <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE:
          if (fall) begin
            state <= START;
            p <= pn;
            cnt <= (pn >> 1) - DIV_W'(1);
          end
        START:
          if (!tick) cnt <= cnt - DIV_W'(1);
          else if (s) state <= IDLE;
          else begin
            state <= DATA;
            idx <= '0;
            cnt <= p - DIV_W'(1);
          end
        DATA:
          if (!tick) cnt <= cnt - DIV_W'(1);
          else begin
            sh <= {s, sh[DATA_BITS-1:1]};
            cnt <= p - DIV_W'(1);
            idx <= idx + IW'(1);
            if (idx == IW'(DATA_BITS - 1)) state <= STOP;
          end
        STOP:
          if (!tick) cnt <= cnt - DIV_W'(1);
          else if (s) begin
            push_v <= 1'b1;
            push_d <= sh;
            state <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state <= WAIT_IDLE;
          end
        WAIT_IDLE:
          if (s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) overrun <= 1'b0;
    else if (drop) overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  bitbanger_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (push_v),
    .wr_data(push_d),
    .rd_en  (rx_ready),
    .rd_data(rx_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );
endmodule

// File: tb/tb_bitbanger_rx.sv
// tb_bitbanger_rx: randomized self-checking bench with a byte-level scoreboard
module tb_bitbanger_rx;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic line0 = 1'b1, line1 = 1'b0;
  logic [16:0] baud_div = 17'd16;
  logic rdy0 = 1'b1, rdy1 = 1'b0, oclr = 1'b0;
  logic [7:0] d0, d1;
  logic v0, v1, fe0, fe1, ov0, ov1, b0, b1;
  int vectors = 0, miscompares = 0, vcyc = 0, fe_cnt = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  bitbanger_rx dut0 (
    .clk(clk), .reset(reset), .rx_line(line0), .baud_div(baud_div),
    .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0), .frame_err(fe0),
    .overrun(ov0), .overrun_clr(oclr), .rx_busy(b0)
  );
  bitbanger_rx #(.INVERT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .rx_line(line1), .baud_div(baud_div),
    .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1), .frame_err(fe1),
    .overrun(ov1), .overrun_clr(oclr), .rx_busy(b1)
  );

  task automatic check(string tag, int got, int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted byte must be the oldest byte the bench expects
  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    #4;
    if (v0) vcyc++;
    if (fe0) fe_cnt++;
    if (v0 && rdy0) begin
      if (q.size() == 0) check("spurious_pop", int'(d0), 'h100);
      else begin
        e = q.pop_front();
        check("pop_data", int'(d0), int'(e));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic int eff(int d);
    return d < 4 ? 4 : d;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(bit tgt, bit v, int n);
    if (tgt) line1 = ~v;
    else line0 = v;
    tick(n);
  endtask

  task automatic send(bit tgt, logic [7:0] b, int per, int stop_low, bit scram);
    logic [16:0] saved;
    saved = baud_div;
    drive(tgt, 1'b0, per);
    if (scram) baud_div = 17'($urandom_range(0, 200));
    for (int i = 0; i < 8; i++) drive(tgt, b[i], per);
    if (stop_low > 0) begin
      drive(tgt, 1'b0, stop_low);
      drive(tgt, 1'b1, 2 * per);
    end else drive(tgt, 1'b1, per);
    baud_div = saved;
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while (q.size() > 0 && n < budget) begin
      tick(1);
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    int fe_base, per, n;
    tick(4);
    check("rst_valid", int'(v0), 0);
    check("rst_data", int'(d0), 0);
    check("rst_ferr", int'(fe0), 0);
    check("rst_ovr", int'(ov0), 0);
    check("rst_busy", int'(b0), 0);
    reset = 1'b1;
    tick(5);

    vcyc = 0;
    q.push_back(8'hA5);
    send(0, 8'hA5, 16, 0, 0);
    tick(8);
    check("a5_drained", q.size(), 0);
    check("a5_valid_cycles", vcyc, 1);
    check("a5_ferr", fe_cnt, 0);
    check("a5_ovr", int'(ov0), 0);

    vcyc = 0;
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 40);
    check("glitch_valid", vcyc, 0);
    check("glitch_ferr", fe_cnt, 0);
    check("glitch_busy", int'(b0), 0);

    send(0, 8'h3C, 16, 40, 0);
    q.push_back(8'h55);
    send(0, 8'h55, 16, 0, 0);
    tick(8);
    check("ferr_count", fe_cnt, 1);
    check("ferr_drained", q.size(), 0);

    rdy0 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) q.push_back(8'(i));
      send(0, 8'(i), 16, 0, 0);
      if (i == 7) check("ovr_at_8", int'(ov0), 0);
    end
    tick(4);
    check("ovr_set", int'(ov0), 1);
    check("ovr_head", int'(d0), 0);
    rdy0 = 1'b1;
    drain(100);
    check("ovr_sticky", int'(ov0), 1);
    oclr = 1'b1;
    tick(1);
    oclr = 1'b0;
    check("ovr_clr", int'(ov0), 0);

    rdy0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      q.push_back(8'h10 + 8'(i));
      send(0, 8'h10 + 8'(i), 16, 0, 0);
    end
    q.push_back(8'h18);
    drive(0, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(0, 1'(8'h18 >> i), 16);
    line0 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b0 && n < 40);
    check("stop_seen", int'(b0), 0);
    #1 rdy0 = 1'b1;
    @(posedge clk);
    #1 rdy0 = 1'b0;
    tick(16);
    check("full_pushpop_ovr", int'(ov0), 0);
    rdy0 = 1'b1;
    drain(100);

    drive(0, 1'b0, 16);
    for (int i = 0; i < 3; i++) drive(0, 1'b1, 16);
    reset = 1'b0;
    #2;
    check("mid_rst_valid", int'(v0), 0);
    check("mid_rst_data", int'(d0), 0);
    check("mid_rst_busy", int'(b0), 0);
    check("mid_rst_ferr", int'(fe0), 0);
    line0 = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(3);
    q.push_back(8'h81);
    send(0, 8'h81, 16, 0, 0);
    tick(8);
    check("post_rst_drained", q.size(), 0);

    reset = 1'b0;
    line0 = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(20);
    check("low_release_busy", int'(b0), 0);
    line0 = 1'b1;
    tick(40);

    baud_div = 17'd3;
    send(1, 8'h42, eff(3), 0, 0);
    tick(6);
    check("inv_valid", int'(v1), 1);
    check("inv_data", int'(d1), 'h42);
    check("inv_ferr", int'(fe1), 0);
    check("inv_ovr", int'(ov1), 0);
    rdy1 = 1'b1;
    tick(1);
    rdy1 = 1'b0;
    check("inv_popped", int'(v1), 0);

    fe_base = fe_cnt;
    for (int k = 0; k < 16; k++) begin
      logic [7:0] b;
      b = 8'($urandom);
      baud_div = 17'($urandom_range(0, 24));
      per = eff(int'(baud_div));
      rdy0 = q.size() > 4 ? 1'b1 : 1'($urandom_range(0, 1));
      q.push_back(b);
      send(0, b, per, 0, 1'($urandom_range(0, 1)));
      drive(0, 1'b1, $urandom_range(0, 10));
    end
    rdy0 = 1'b1;
    drain(200);
    check("rand_ferr", fe_cnt, fe_base);
    check("rand_ovr", int'(ov0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bitbanger_rx.md
Name: bitbanger_rx

Overview:
- Serial receiver for the CoCo bit-banger RS-232 output: PIA1 port A bit 1 (rsout1), driven by software bit-banging from the 6809.
- Recovers 8N1 frames at a runtime-selectable bit period and buffers bytes in a small FIFO.
- Hands bytes to the host/HPS side (debug console, printer capture) over a valid/ready interface.
- Sits at top level beside pia1, clocked by the 57.272 MHz system clk.

Parameters:
- DIV_W, 17, width of bit-period divider; default covers 600 baud at 57.272 MHz (95453 clocks).
- FIFO_DEPTH, 8, receive FIFO entries; must be a power of two, minimum 2.
- INVERT, 0, 1 = invert line before decoding (idle low on pin).

Ports:
- clk  input  1  system clock, 57.272 MHz.
- reset  input  1  asynchronous, active-low reset; all state cleared while low.
- rx_line  input  1  serial line (rsout1), asynchronous to clk; idle = mark = 1 after optional inversion.
- baud_div  input  DIV_W  clocks per bit; values below 4 are treated as 4; sampled only at start-bit detection.
- rx_data  output  8  byte at FIFO head (first-word fall-through).
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready at a rising clk edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- overrun_clr  input  1  clears overrun; set wins if both occur in the same cycle.
- rx_busy  output  1  1 in any state other than IDLE.

Behaviour:
- Reset values: rx_valid=0, rx_data=0, frame_err=0, overrun=0, rx_busy=0, FIFO empty, state IDLE, synchroniser flops=1.
- Input path:
  - 2-flop synchroniser, then INVERT XOR.
  - Decoder sees line value s; falling-edge detect on s against its previous value.
- Divider:
  - Counter cnt counts down to 0, then reloads.
  - Period P latched at start detection as max(baud_div, 4).
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on falling edge of s -> START; latch P; cnt = (P>>1) - 1 (mid-bit).
  - START: at cnt==0, sample s. If s==1 -> IDLE (glitch, no error). If s==0 -> DATA; bit index=0; cnt=P-1.
  - DATA: at cnt==0, shift s into the MSB of an 8-bit shift register (LSB first on the wire); reload cnt=P-1. After the 8th sample -> STOP.
  - STOP, s==1 at cnt==0: push byte -> IDLE. A new start edge is then accepted the next cycle, with no dead time.
  - STOP, s==0 at cnt==0: frame_err pulse for 1 cycle; byte discarded -> WAIT_IDLE.
  - WAIT_IDLE: stay until s==1 (covers break); then -> IDLE.
- Latency: byte appears on rx_valid 2 cycles after the stop-bit sample cycle (1 push register + FIFO write).
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - Empty when pointers are equal; full when MSBs differ and the rest are equal.
  - Pop when rx_valid && rx_ready.
  - Push when full and no pop: byte dropped, overrun<=1, FIFO unchanged.
  - Push and pop in the same cycle while full: both happen, no overrun.
  - Push and pop in the same cycle while empty: not possible (rx_valid=0), push only.
- rx_data is stable while rx_valid=1 and no pop occurs.
- Asynchronous reset mid-frame: FSM -> IDLE, FIFO emptied, partial byte lost. After release, a line already low is not taken as a start bit; a falling edge is required.
- A baud_div change mid-frame has no effect until the next start bit.

Decomposition:
- Shared package bitbanger_pkg: FSM state enum (3-bit encoding); constants MIN_DIV=4, DATA_BITS=8.
- One sub-module, bitbanger_fifo: synchronous FIFO, FWFT, parameterised by depth and width, with full/empty outputs.
- Synchroniser, divider and FSM stay in bitbanger_rx.

Test Plan:
- baud_div=16, send 8N1 0xA5 (start 0, bits 1,0,1,0,0,1,0,1 LSB first, stop 1), rx_ready=1 -> rx_data=0xA5 with rx_valid high for exactly 1 cycle; frame_err=0; overrun=0.
- baud_div=16, 4-clock low glitch on idle line -> returns to IDLE at mid-start sample; rx_valid stays 0; frame_err=0.
- baud_div=16, frame 0x3C with stop bit held 0 for 40 clocks, then 0x55 -> one frame_err pulse; only 0x55 delivered.
- FIFO_DEPTH=8, rx_ready=0, send 0x00..0x08 (9 bytes) -> overrun=1 after the 9th stop bit; draining yields 0x00..0x07 in order; overrun_clr -> overrun=0.
- FIFO full, rx_ready pulsed in the same cycle as the 9th byte's push -> no overrun; 9th byte retained at the tail.
- Assert reset low mid-DATA of 0xFF, release, send 0x81 -> only 0x81 received; outputs at reset values during reset.
- INVERT=1, baud_div=3 (clamped to 4), inverted-level frame 0x42 -> rx_data=0x42.
